// File: rtl/acc_pkg.sv
// Shared op codes and widths for the accumulator datapath.
// Optional saturation mode is selected by ACC_SAT_EN (see acc_unit).
package acc_pkg;

  localparam int ACC_OPW = 3;

  typedef enum logic [ACC_OPW-1:0] {
    OP_NOP = 3'd0,
    OP_LD  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHR = 3'd7
  } acc_op_e;

endpackage

// File: rtl/acc_unit_if.sv
// Control/status bundle between the control unit (master) and the accumulator (slave).
interface acc_if
  import acc_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic               en;
  logic [ACC_OPW-1:0] op;
  logic [WIDTH-1:0]   in;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   acc;
  logic               flag_z;
  logic               flag_n;
  logic               flag_c;
  logic               flag_v;
  logic               stk_full;
  logic               stk_empty;
  logic               err;

  modport master (
    output en, op, in, push, pop,
    input  acc, flag_z, flag_n, flag_c, flag_v, stk_full, stk_empty, err
  );

  modport slave (
    input  en, op, in, push, pop,
    output acc, flag_z, flag_n, flag_c, flag_v, stk_full, stk_empty, err
  );

endinterface

// File: rtl/acc_stack.sv
// LIFO save stack for the accumulator; flags illegal accesses with a one-cycle err_pulse.
module acc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             pop_taken,
  output logic             full,
  output logic             empty,
  output logic             err_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_taken;
  logic [AW-1:0]    top_idx;

  always_comb begin
    push_taken = push && !pop && !full;
    pop_taken  = pop && !push && !empty;
    err_pulse  = (push && pop) || (push && full) || (pop && empty);
    count_nxt  = count;
    if (push_taken)
      count_nxt = count + CW'(1);
    else if (pop_taken)
      count_nxt = count - CW'(1);
    top_idx = count[AW-1:0] - AW'(1);
    top     = mem[top_idx];
  end

  // full/empty are registered from the next count so they always match it
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_taken)
      mem[count[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulator with registered ALU op, status flags and a save stack.
// Define ACC_SAT_EN to make ADD/SUB saturate to the signed limits instead of wrapping.
module acc_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  acc_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] acc_q;
  logic             z_q, n_q, c_q, v_q, err_q;
  logic [WIDTH-1:0] stk_top;
  logic             pop_taken, stk_full, stk_empty, err_pulse;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic             c_nxt, v_nxt;
  acc_op_e          op;

  acc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.push),
    .pop       (bus.pop),
    .wdata     (acc_q),
    .top       (stk_top),
    .pop_taken (pop_taken),
    .full      (stk_full),
    .empty     (stk_empty),
    .err_pulse (err_pulse)
  );

  always_comb begin
    op    = acc_op_e'(bus.op);
    sum   = {1'b0, acc_q} + {1'b0, bus.in};
    diff  = {1'b0, acc_q} - {1'b0, bus.in};
    res   = acc_q;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (op)
      OP_LD:  res = bus.in;
      OP_ADD: begin
        res   = sum[MSB:0];
        c_nxt = sum[WIDTH];
        v_nxt = (acc_q[MSB] == bus.in[MSB]) && (sum[MSB] != acc_q[MSB]);
      end
      OP_SUB: begin
        res   = diff[MSB:0];
        c_nxt = diff[WIDTH];
        v_nxt = (acc_q[MSB] != bus.in[MSB]) && (diff[MSB] != acc_q[MSB]);
      end
      OP_AND: res = acc_q & bus.in;
      OP_OR:  res = acc_q | bus.in;
      OP_XOR: res = acc_q ^ bus.in;
      OP_SHR: begin
        res   = {1'b0, acc_q[MSB:1]};
        c_nxt = acc_q[0];
      end
      default: res = acc_q;
    endcase
`ifdef ACC_SAT_EN
    // On overflow the result's true sign is the old acc's sign in both ADD and SUB
    if ((op == OP_ADD || op == OP_SUB) && v_nxt)
      res = acc_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`else
    res = res;
`endif
  end

  // A legal pop takes priority over the ALU op presented in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_pulse;
      if (pop_taken) begin
        acc_q <= stk_top;
        z_q   <= (stk_top == '0);
        n_q   <= stk_top[MSB];
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (bus.en && op != OP_NOP) begin
        acc_q <= res;
        z_q   <= (res == '0);
        n_q   <= res[MSB];
        c_q   <= c_nxt;
        v_q   <= v_nxt;
      end
    end
  end

  assign bus.acc       = acc_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: directed scenarios then randomized traffic against an
// arithmetic reference model. Honours ACC_SAT_EN in the model when defined.
module tb_acc_unit;
  import acc_pkg::*;

  localparam int W    = 16;
  localparam int D    = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_if #(.WIDTH(W)) bus ();

  acc_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_acc;
  bit m_z, m_n, m_c, m_v, m_err;
  int m_stk[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int to_signed(input int u);
    return (u >= (1 << (W - 1))) ? u - (1 << W) : u;
  endfunction

  function automatic bit ovf(input int s);
    return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endfunction

  // Reference behaviour: plain integer arithmetic and a queue for the stack
  task automatic modelStep(input bit en, input int op, input int din, input bit push, input bit pop);
    int old, s;
    bit do_pop, do_push;
    if (!rst) begin
      m_acc = 0; m_c = 0; m_v = 0; m_err = 0;
      m_stk.delete();
    end else begin
      old = m_acc;
      if ((push && pop) || (push && m_stk.size() == D) || (pop && m_stk.size() == 0))
        m_err = 1;
      do_pop  = pop && !push && m_stk.size() > 0;
      do_push = push && !pop && m_stk.size() < D;
      if (do_pop) begin
        m_acc = m_stk.pop_back();
        m_c = 0; m_v = 0;
      end else if (en && op != 0) begin
        m_c = 0; m_v = 0;
        case (op)
          1: m_acc = din;
          2: begin
            m_acc = (old + din) & MASK;
            m_c   = (old + din) > MASK;
            s     = to_signed(old) + to_signed(din);
            m_v   = ovf(s);
`ifdef ACC_SAT_EN
            if (m_v) m_acc = (s > 0) ? (1 << (W - 1)) - 1 : (1 << (W - 1));
`endif
          end
          3: begin
            m_acc = (old - din) & MASK;
            m_c   = old < din;
            s     = to_signed(old) - to_signed(din);
            m_v   = ovf(s);
`ifdef ACC_SAT_EN
            if (m_v) m_acc = (s > 0) ? (1 << (W - 1)) - 1 : (1 << (W - 1));
`endif
          end
          4: m_acc = old & din;
          5: m_acc = old | din;
          6: m_acc = old ^ din;
          default: begin
            m_acc = old / 2;
            m_c   = old % 2;
          end
        endcase
      end
      if (do_push) m_stk.push_back(old);
    end
    m_z = (m_acc == 0);
    m_n = m_acc >= (1 << (W - 1));
  endtask

  task automatic checkAll();
    checkOutput("acc",       bus.acc,       32'(m_acc));
    checkOutput("flag_z",    bus.flag_z,    32'(m_z));
    checkOutput("flag_n",    bus.flag_n,    32'(m_n));
    checkOutput("flag_c",    bus.flag_c,    32'(m_c));
    checkOutput("flag_v",    bus.flag_v,    32'(m_v));
    checkOutput("stk_full",  bus.stk_full,  32'(m_stk.size() == D));
    checkOutput("stk_empty", bus.stk_empty, 32'(m_stk.size() == 0));
    checkOutput("err",       bus.err,       32'(m_err));
  endtask

  task automatic applyStimulus(input bit en, input int op, input int din, input bit push, input bit pop);
    bus.en   = en;
    bus.op   = op[ACC_OPW-1:0];
    bus.in   = din[W-1:0];
    bus.push = push;
    bus.pop  = pop;
    @(posedge clk);
    modelStep(en, op, din, push, pop);
    #1;
    checkAll();
  endtask

  function automatic int pickOperand();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return (1 << (W - 1)) - 1;
      3: return 1 << (W - 1);
      4: return MASK;
      default: return int'($urandom_range(0, MASK));
    endcase
  endfunction

  initial begin
    int vals[4];
    vals = '{'hA, 'hB, 'hC, 'hD};
    bus.en = 0; bus.op = '0; bus.in = '0; bus.push = 0; bus.pop = 0;

    // reset held with a live LD
    rst = 0;
    applyStimulus(1, 1, 'h1234, 0, 0);
    applyStimulus(1, 1, 'h1234, 0, 0);
    checkOutput("t1_rst_acc", bus.acc, 32'h0);
    checkOutput("t1_rst_z", bus.flag_z, 32'h1);
    rst = 1;
    applyStimulus(1, 1, 'h1234, 0, 0);
    checkOutput("t1_ld", bus.acc, 32'h1234);

    applyStimulus(1, 1, 'h7FFF, 0, 0);
    applyStimulus(1, 2, 'h0001, 0, 0);
`ifdef ACC_SAT_EN
    checkOutput("t2_acc", bus.acc, 32'h7FFF);
`else
    checkOutput("t2_acc", bus.acc, 32'h8000);
`endif
    checkOutput("t2_v", bus.flag_v, 32'h1);

    applyStimulus(1, 1, 'h0003, 0, 0);
    applyStimulus(1, 3, 'h0005, 0, 0);
    checkOutput("t3_acc", bus.acc, 32'hFFFE);
    checkOutput("t3_c", bus.flag_c, 32'h1);
    applyStimulus(1, 3, 'hFFFE, 0, 0);
    checkOutput("t3_z", bus.flag_z, 32'h1);

    applyStimulus(1, 1, 'h0005, 0, 0);
    applyStimulus(1, 7, 0, 0, 0);
    checkOutput("t4_shr", bus.acc, 32'h0002);
    checkOutput("t4_c", bus.flag_c, 32'h1);
    applyStimulus(1, 6, 'h0002, 0, 0);
    checkOutput("t4_xor_z", bus.flag_z, 32'h1);

    foreach (vals[i]) begin
      applyStimulus(1, 1, vals[i], 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
    end
    checkOutput("t5_full", bus.stk_full, 32'h1);
    checkOutput("t5_err0", bus.err, 32'h0);
    applyStimulus(1, 1, 'h55, 1, 0);
    checkOutput("t5_err1", bus.err, 32'h1);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1, 2, 'h1, 0, 1);
      checkOutput("t5_pop", bus.acc, 32'(vals[i]));
    end
    checkOutput("t5_empty", bus.stk_empty, 32'h1);

    rst = 0;
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_err_pop", bus.err, 32'h1);
    checkOutput("t6_held", bus.acc, 32'h0);
    applyStimulus(1, 2, 1, 1, 1);
    checkOutput("t6_pushpop_acc", bus.acc, 32'h1);
    checkOutput("t6_pushpop_empty", bus.stk_empty, 32'h1);

    // mid-sequence reset discards stack contents
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    rst = 0;
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1;
    checkOutput("t7_empty", bus.stk_empty, 32'h1);

    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 99) != 0);
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), pickOperand(),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
